// File: rtl/bist_resp_compactor.sv
// Logic-BIST controller: exhaustive counter patterns out, MISR compaction
// of CUT responses in, golden-signature compare at the end of a session.
module bist_resp_compactor #(
  parameter int                PI_W      = 5,
  parameter int                PO_W      = 2,
  parameter int                MISR_W    = 8,
  parameter logic [MISR_W-1:0] MISR_POLY = 8'h1D,
  parameter int                NUM_PAT   = 32,
  parameter int                CUT_LAT   = 0
) (
  input  logic              CK,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MISR_W-1:0] golden,
  output logic [PI_W-1:0]   pat_out,
  input  logic [PO_W-1:0]   resp_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] signature
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [PI_W-1:0] LAST  = PI_W'(NUM_PAT - 1);
  localparam logic [2:0]      DLAST = 3'(CUT_LAT - 1);

  logic [1:0]        r_state;
  logic [PI_W-1:0]   r_pat;
  logic [2:0]        r_drn;
  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] r_gold;
  logic              r_done;
  logic              r_pass;

  logic              w_accept;
  logic              w_apply;
  logic              w_last;
  logic              w_drain_end;
  logic              w_to_done;
  logic              w_cap;
  logic [MISR_W-1:0] w_fb;
  logic [MISR_W-1:0] w_sig_next;
  logic [MISR_W-1:0] w_sig_upd;

  assign w_accept    = start &&
                       (r_state == S_IDLE || r_state == S_DONE);
  assign w_apply     = (r_state == S_APPLY);
  assign w_last      = w_apply && (r_pat == LAST);
  assign w_drain_end = (r_state == S_DRAIN) && (r_drn == DLAST);
  assign w_to_done   = (w_last && CUT_LAT == 0) || w_drain_end;

  assign w_fb       = r_sig[MISR_W-1] ? MISR_POLY : '0;
  assign w_sig_next = {r_sig[MISR_W-2:0], 1'b0} ^ w_fb
                    ^ MISR_W'(resp_in);
  assign w_sig_upd  = w_cap ? w_sig_next : r_sig;

  // Valid pipe aligns each capture with the CUT's response latency
  if (CUT_LAT == 0) begin : g_nopipe
    assign w_cap = w_apply;
  end else begin : g_pipe
    logic [CUT_LAT-1:0] r_vp;
    always_ff @(posedge CK or negedge rst_n) begin
      if (!rst_n) begin
        r_vp <= '0;
      end else begin
        r_vp[0] <= w_apply;
        for (int i = 1; i < CUT_LAT; i++)
          r_vp[i] <= r_vp[i-1];
      end
    end
    assign w_cap = r_vp[CUT_LAT-1];
  end

  always_ff @(posedge CK or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pat   <= '0;
      r_drn   <= '0;
      r_sig   <= '0;
      r_gold  <= '0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_state <= S_APPLY;
        r_pat   <= '0;
        r_drn   <= '0;
        r_sig   <= '0;
        r_gold  <= golden;
        r_pass  <= 1'b0;
      end else begin
        r_sig <= w_sig_upd;
        unique case (r_state)
          S_APPLY: begin
            if (w_last) begin
              r_pat   <= '0;
              r_state <= (CUT_LAT == 0) ? S_DONE : S_DRAIN;
            end else begin
              r_pat <= r_pat + 1'b1;
            end
          end
          S_DRAIN: begin
            if (w_drain_end) r_state <= S_DONE;
            else             r_drn   <= r_drn + 1'b1;
          end
          default: ;
        endcase
        // Compare includes the final capture landing on this edge
        if (w_to_done) begin
          r_done <= 1'b1;
          r_pass <= (w_sig_upd == r_gold);
        end
      end
    end
  end

  assign pat_out   = r_pat;
  assign busy      = (r_state == S_APPLY) || (r_state == S_DRAIN);
  assign done      = r_done;
  assign pass      = r_pass;
  assign signature = r_sig;

endmodule

// File: tb/tb_bist_resp_compactor.sv
// Randomized bench: two controllers (latency 0 and 2) around a LUT CUT,
// checked against a signature computed from the response list.
module tb_bist_resp_compactor;

  localparam int          NP   = 32;
  localparam int          LAT  = 2;
  localparam logic [7:0]  POLY = 8'h1D;

  logic       CK = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] gold_a = '0;
  logic [7:0] gold_b = '0;

  logic [4:0] pat_a, pat_b;
  logic [1:0] resp_a, resp_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] sig_a, sig_b;

  logic [1:0] lut [NP];
  logic [1:0] noise = '0;
  logic [1:0] d1 = '0, d2 = '0;
  logic [7:0] exps [NP+1];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CK = ~CK;

  assign resp_a = busy_a ? lut[pat_a] : noise;
  assign resp_b = d2;

  always @(posedge CK) begin
    d1 <= lut[pat_b];
    d2 <= d1;
  end

  bist_resp_compactor #(.CUT_LAT(0)) u_a (
    .CK(CK), .rst_n(rst_n), .start(start), .golden(gold_a),
    .pat_out(pat_a), .resp_in(resp_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .signature(sig_a)
  );

  bist_resp_compactor #(.CUT_LAT(LAT)) u_b (
    .CK(CK), .rst_n(rst_n), .start(start), .golden(gold_b),
    .pat_out(pat_b), .resp_in(resp_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .signature(sig_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic [7:0] s,
                                      input logic [1:0] r);
    int v;
    v = int'(s) * 2;
    if (v >= 256) v = (v - 256) ^ int'(POLY);
    return 8'(v) ^ {6'd0, r};
  endfunction

  task automatic build();
    exps[0] = '0;
    for (int k = 0; k < NP; k++)
      exps[k+1] = step(exps[k], lut[k]);
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
    noise = 2'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pat"}, {27'd0, pat_a, pat_b} , 0);
    chk({tag, "_ctl"}, {busy_a, done_a, pass_a, busy_b, done_b, pass_b}, 0);
    chk({tag, "_sig"}, {sig_a, sig_b}, 0);
  endtask

  task automatic session(input logic [7:0] ga, input logic [7:0] gb,
                         input int mid, input int abort_at);
    int ba = 0, bb = 0, da = 0, db = 0, db_at = -1;
    build();
    gold_a = ga; gold_b = gb; start = 1'b1;
    tick();
    start = 1'b0; gold_a = 8'($urandom); gold_b = 8'($urandom);
    for (int n = 0; n < 40; n++) begin
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_zero("abort");
        tick(); tick();
        chk("abort_nodone", {done_a, done_b}, 0);
        rst_n = 1'b1;
        tick();
        chk("abort_idle", {busy_a, busy_b, done_a, done_b}, 0);
        return;
      end
      if (n < NP) begin
        chk("pat_a", pat_a, n);
        chk("pat_b", pat_b, n);
        chk("sig_a", sig_a, exps[n]);
      end
      if (n == NP) begin
        chk("fin_sig_a", sig_a, exps[NP]);
        chk("fin_pass_a", pass_a, ga == exps[NP]);
        chk("done_a_at", done_a, 1);
      end
      if (n == NP + LAT) begin
        chk("fin_sig_b", sig_b, exps[NP]);
        chk("fin_pass_b", pass_b, gb == exps[NP]);
      end
      if (busy_a) ba++;
      if (busy_b) bb++;
      if (done_a) da++;
      if (done_b) begin db++; db_at = n; end
      start = (n == mid);
      if (n == mid) begin gold_a = ~ga; gold_b = ~gb; end
      tick();
    end
    start = 1'b0;
    chk("busy_len_a", ba, NP);
    chk("busy_len_b", bb, NP + LAT);
    chk("done_cnt_a", da, 1);
    chk("done_cnt_b", db, 1);
    chk("done_b_at", db_at, NP + LAT);
    chk("pass_hold_a", pass_a, ga == exps[NP]);
    chk("pat_idle", {pat_a, pat_b}, 0);
  endtask

  task automatic restart_in_done();
    int da = 0, db = 0;
    logic [7:0] gb;
    build();
    gb = exps[NP];
    gold_a = ~exps[NP]; gold_b = gb; start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < NP; n++) tick();
    chk("rd_done_a", done_a, 1);
    chk("rd_pass_a", pass_a, 0);
    start = 1'b1; gold_a = exps[NP]; gold_b = ~gb;
    tick();
    start = 1'b0;
    chk("rd_busy_a", busy_a, 1);
    chk("rd_done_clr", done_a, 0);
    chk("rd_sig_clr", sig_a, 0);
    chk("rd_pass_clr", pass_a, 0);
    chk("rd_pat0", pat_a, 0);
    for (int m = 0; m < 40; m++) begin
      if (done_a) da++;
      if (done_b) db++;
      tick();
    end
    chk("rd_done_cnt_a", da, 1);
    chk("rd_done_cnt_b", db, 1);
    chk("rd_sig_a", sig_a, exps[NP]);
    chk("rd_pass_a2", pass_a, 1);
    chk("rd_pass_b", pass_b, 1);
  endtask

  initial begin
    for (int k = 0; k < NP; k++) lut[k] = '0;
    tick(); tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();
    chk_zero("idle");

    // constant 01 response: 01,03,..,FF then feedback E2
    for (int k = 0; k < NP; k++) lut[k] = 2'b01;
    build();
    chk("step8", exps[8], 8'hFF);
    chk("step9", exps[9], 8'hE2);
    session(exps[NP], exps[NP] ^ 8'h01, -1, -1);

    for (int k = 0; k < NP; k++) lut[k] = '0;
    session(8'h00, 8'h00, -1, -1);

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NP; k++) lut[k] = 2'($urandom);
      build();
      session(exps[NP], exps[NP], 10, -1);
    end

    for (int k = 0; k < NP; k++) lut[k] = 2'($urandom);
    session(8'h00, 8'h00, -1, 10);
    build();
    session(exps[NP], exps[NP], -1, -1);

    for (int k = 0; k < NP; k++) lut[k] = 2'($urandom);
    restart_in_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bist_resp_compactor.md
Name: bist_resp_compactor

Overview:
- Logic-BIST controller placed around a small combinational benchmark CUT (5-PI/2-PO class) on the ATPG test bench.
- Drives exhaustive counter patterns into the CUT's primary inputs and reads its primary outputs.
- Compacts the responses into a MISR signature and compares the signature to a golden value.
- It is the pattern-source/response-reader counterpart of a gate-level CUT netlist and is used to cross-check fault-simulation signatures.

Parameters:
- PI_W, 5, CUT primary-input width (pattern width).
- PO_W, 2, CUT primary-output width (response width); must be <= MISR_W.
- MISR_W, 8, signature register width.
- MISR_POLY, 8'h1D, feedback taps, bit i = tap on bit i (x^MISR_W implicit).
- NUM_PAT, 32, patterns per session, 1..2^PI_W.
- CUT_LAT, 0, CUT pipeline latency in cycles, 0..7.

Ports:
- CK  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle session request; honoured only in IDLE or DONE.
- golden  in  MISR_W  expected signature; sampled on the accepted start.
- pat_out  out  PI_W  pattern to the CUT PIs, registered.
- resp_in  in  PO_W  CUT PO response.
- busy  out  1  high in APPLY and DRAIN.
- done  out  1  one-cycle pulse on entry to DONE.
- pass  out  1  signature==golden; valid in DONE, held until the next accepted start.
- signature  out  MISR_W  current MISR contents.

Behaviour:
- Reset (async assert, sync release): state=IDLE, pat_out=0, busy=0, done=0, pass=0, signature=0, pattern count=0, capture pipe cleared.
- FSM IDLE -> APPLY: on start. Same edge: signature<=0, pattern count<=0, pat_out<=0, golden latched, pass<=0.
- FSM APPLY: one pattern per cycle. The pattern index k is on pat_out during APPLY cycle k, for k=0..NUM_PAT-1. After cycle NUM_PAT-1, go to DRAIN if CUT_LAT>0, else to DONE.
- FSM DRAIN: exactly CUT_LAT cycles, then go to DONE.
- FSM DONE: done=1 for the first cycle only; state stays DONE until start.
- Capture pipe: a CUT_LAT-deep valid shift register fed with 1 for each APPLY cycle. The MISR updates on every cycle whose delayed valid=1. Total updates per session = NUM_PAT exactly, so the response to pattern k is captured at edge k+CUT_LAT.
- MISR update: next = (sig<<1) ^ (sig[MISR_W-1] ? MISR_POLY : 0) ^ zero_extend(resp_in). Truncate to MISR_W.
- pass: registered on the DONE-entry edge as (final signature == latched golden).
- pat_out in IDLE/DONE: holds 0. Patterns are binary count values, no wrap within a session (NUM_PAT <= 2^PI_W).
- start while busy: ignored. The latched golden is not updated.
- start in the DONE cycle: accepted. Starts a new session, and done is not asserted again that cycle.
- Reset mid-session: aborts immediately to the reset state. No done pulse.
- Simultaneous start and rst_n low: reset wins.
- resp_in: sampled only on capture cycles; X/changes on other cycles have no effect.
- Session length: NUM_PAT+CUT_LAT busy cycles from the accepted start to done.

Test Plan:
- Defaults, resp_in tied 0, golden=0, one start pulse -> pat_out steps 0..31 over 32 cycles; busy=1 for 32 cycles; done pulses once; signature=8'h00; pass=1.
- Defaults, resp_in tied 2'b01, NUM_PAT=8 -> signature 01,03,07,0F,1F,3F,7F,FF after successive captures; golden=8'hFF -> pass=1.
- Feedback check, NUM_PAT=9 with resp_in=2'b01 -> 9th capture: FF -> FE^1D^01 = 8'hE2; golden=8'hE3 -> pass=0.
- CUT_LAT=2 with a 2-stage delayed model CUT computing resp=pat[1:0] -> busy lasts 34 cycles, done at cycle 34, signature equals the CUT_LAT=0 result for the same CUT; start asserted mid-session ignored.
- Assert rst_n low at APPLY cycle 10 -> all outputs 0 immediately, no done. Restart after release -> full 32-pattern session, same signature as the uninterrupted run.
- start in the DONE cycle -> new session begins the next cycle with signature cleared and pass cleared, and no second done pulse.
